// File: rtl/multi_lane_engine.sv
// multi_lane_engine: multi-lane note-shift game core with hit/penalty/miss scoring
// Ports: clk, resetn (async active-low); run (play level), load (pattern load pulse),
//        pattern_in (lane i at [i*LANE_LEN +: LANE_LEN]), btn (raw per-lane buttons);
//        lane_view (low VIEW_W bits per lane), score, combo, tick (shift pulse),
//        state (IDLE=0 RUN=1 PAUSE=2 DONE=3)
module multi_lane_engine #(
  parameter int NUM_LANES = 4,
  parameter int LANE_LEN  = 64,
  parameter int VIEW_W    = 10,
  parameter int TICK_DIV  = 9000000,
  parameter int SCORE_W   = 8,
  parameter int COMBO_W   = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          run,
  input  logic                          load,
  input  logic [NUM_LANES*LANE_LEN-1:0] pattern_in,
  input  logic [NUM_LANES-1:0]          btn,
  output logic [NUM_LANES*VIEW_W-1:0]   lane_view,
  output logic [SCORE_W-1:0]            score,
  output logic [COMBO_W-1:0]            combo,
  output logic                          tick,
  output logic [1:0]                    state
);
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int CW    = $clog2(NUM_LANES + 1);
  localparam int SW    = SCORE_W + CW + 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
  logic [1:0]                           state_q, state_d;
  logic [NUM_LANES-1:0][LANE_LEN-1:0]   lanes_q, lanes_d;
  logic [DIV_W-1:0]                     div_q, div_d;
  logic [SCORE_W-1:0]                   score_q, score_d;
  logic [COMBO_W-1:0]                   combo_q, combo_d;
  logic                                 loaded_q, loaded_d;
  logic [NUM_LANES-1:0]                 s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [NUM_LANES-1:0]                 press, hit, bad;
  logic [CW-1:0]                        n_hit, n_bad;
  logic [SW-1:0]                        sum;
  logic [COMBO_W+CW-1:0]                csum;
  logic                                 running, at_tick;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = load ? IDLE :
              state_q == IDLE  ? ((run && loaded_q) ? RUN : IDLE) :
              state_q == RUN   ? ((at_tick && lanes_d == '0) ? DONE : run ? RUN : PAUSE) :
              state_q == PAUSE ? (run ? RUN : PAUSE) : DONE;
  always_comb begin
    running = state_q == RUN;
    at_tick = running && div_q == DIV_MAX;
    tick    = at_tick;
    state   = state_q;
    score   = score_q;
    combo   = combo_q;
  end
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_view
    assign lane_view[i*VIEW_W +: VIEW_W] = lanes_q[i][VIEW_W-1:0];
  end
  always_comb begin
    s1_d     = btn;
    s2_d     = s1_q;
    s3_d     = s2_q;
    press    = s2_q & ~s3_q & {NUM_LANES{running}};
    lanes_d  = lanes_q;
    hit      = '0;
    bad      = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      hit[l]        = press[l] & lanes_q[l][0];
      // a press on an empty slot is a penalty; an unconsumed note leaving on a tick is a miss
      bad[l]        = (press[l] & ~lanes_q[l][0]) | (at_tick & lanes_q[l][0] & ~hit[l]);
      lanes_d[l][0] = lanes_q[l][0] & ~hit[l];
      lanes_d[l]    = at_tick ? lanes_d[l] >> 1 : lanes_d[l];
    end
    n_hit    = CW'($countones(hit));
    n_bad    = CW'($countones(bad));
    sum      = SW'(score_q) + SW'(n_hit) - SW'(n_bad);
    score_d  = sum[SW-1] ? '0 : |sum[SW-2:SCORE_W] ? '1 : sum[SCORE_W-1:0];
    csum     = (COMBO_W+CW)'(combo_q) + (COMBO_W+CW)'(n_hit);
    combo_d  = |n_bad ? '0 : |csum[COMBO_W+CW-1:COMBO_W] ? '1 : csum[COMBO_W-1:0];
    div_d    = !running ? div_q : at_tick ? '0 : div_q + 1'b1;
    loaded_d = loaded_q;
    if (load) begin
      lanes_d  = pattern_in;
      score_d  = '0;
      combo_d  = '0;
      div_d    = '0;
      loaded_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      lanes_q  <= '0;
      div_q    <= '0;
      score_q  <= '0;
      combo_q  <= '0;
      loaded_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
    end else begin
      lanes_q  <= lanes_d;
      div_q    <= div_d;
      score_q  <= score_d;
      combo_q  <= combo_d;
      loaded_q <= loaded_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
    end
endmodule

// File: tb/tb_multi_lane_engine.sv
// tb_multi_lane_engine: directed and random checks of multi_lane_engine against a reference model
module tb_multi_lane_engine;
  localparam int NL = 4, LL = 16, VW = 4, TD = 4, SWD = 4, CWD = 4;
  localparam int SMAX = (1 << SWD) - 1, CMAX = (1 << CWD) - 1;
  logic clk = 0, resetn = 1, run = 0, load = 0;
  logic [NL*LL-1:0] pattern_in = '0;
  logic [NL-1:0]    btn = '0;
  logic [NL*VW-1:0] lane_view;
  logic [SWD-1:0]   score;
  logic [CWD-1:0]   combo;
  logic             tick;
  logic [1:0]       state;
  int errors = 0, checks = 0, ticks;
  logic [LL-1:0] ml [NL];
  int ms, mc, md, mst;
  bit mld;
  logic [NL-1:0] h0, h1, h2;
  logic [NL*VW-1:0] frozen;
  multi_lane_engine #(.NUM_LANES(NL), .LANE_LEN(LL), .VIEW_W(VW), .TICK_DIV(TD),
                      .SCORE_W(SWD), .COMBO_W(CWD)) dut (
    .clk(clk), .resetn(resetn), .run(run), .load(load), .pattern_in(pattern_in),
    .btn(btn), .lane_view(lane_view), .score(score), .combo(combo), .tick(tick),
    .state(state));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    foreach (ml[i]) ml[i] = '0;
    ms = 0; mc = 0; md = 0; mst = 0; mld = 0;
    h0 = '0; h1 = '0; h2 = '0;
  endtask
  // A press is judged at the second edge after the edge that first samples the rise.
  task automatic model_edge();
    logic [NL-1:0] pr;
    int hits, bad;
    bit tk, empty;
    pr = h1 & ~h2;
    h2 = h1; h1 = h0; h0 = btn;
    if (load) begin
      for (int i = 0; i < NL; i++) ml[i] = pattern_in[i*LL +: LL];
      ms = 0; mc = 0; md = 0; mst = 0; mld = 1;
      return;
    end
    tk = (mst == 1) && (md == TD - 1);
    hits = 0; bad = 0; empty = 1;
    for (int i = 0; i < NL; i++) begin
      if (mst == 1 && pr[i]) begin
        if (ml[i][0]) begin hits++; ml[i][0] = 1'b0; end
        else bad++;
      end
      if (tk) begin
        if (ml[i][0]) bad++;
        ml[i] = ml[i] >> 1;
      end
      if (ml[i] != 0) empty = 0;
    end
    ms = ms + hits - bad;
    if (ms < 0) ms = 0;
    if (ms > SMAX) ms = SMAX;
    mc = (bad > 0) ? 0 : (mc + hits > CMAX ? CMAX : mc + hits);
    if (mst == 1) md = tk ? 0 : md + 1;
    case (mst)
      0: if (run && mld) mst = 1;
      1: mst = (tk && empty) ? 3 : (run ? 1 : 2);
      2: if (run) mst = 1;
      default: ;
    endcase
  endtask
  task automatic compare();
    logic [NL*VW-1:0] ev;
    for (int i = 0; i < NL; i++) ev[i*VW +: VW] = ml[i][VW-1:0];
    check("state", state, mst);
    check("score", score, ms);
    check("combo", combo, mc);
    check("tick", tick, (mst == 1 && md == TD - 1));
    check("lane_view", lane_view, ev);
  endtask
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask
  task automatic do_reset();
    resetn = 0;
    #1;
    model_reset();
    compare();
    @(posedge clk);
    #1;
    compare();
    resetn = 1;
  endtask
  task automatic do_load(input logic [NL*LL-1:0] p);
    pattern_in = p;
    load = 1;
    cyc();
    load = 0;
  endtask
  task automatic period(input logic [NL-1:0] m);
    btn = m; cyc(); cyc();
    btn = '0; cyc(); cyc();
  endtask
  initial begin
    #2;
    do_reset();
    check("rst_state", state, 0);
    check("rst_score", score, 0);
    run = 1;
    repeat (3) cyc();
    check("idle_without_load", state, 0);
    do_load(64'h0003);
    ticks = 0;
    for (int i = 0; i < 20 && state != 2'd3; i++) begin
      cyc();
      if (tick) ticks++;
    end
    check("floor_done", state, 3);
    check("floor_ticks", ticks, 2);
    check("floor_score", score, 0);
    check("floor_view", lane_view, 0);
    do_load(64'h0001);
    btn = 4'h1;
    cyc(); cyc(); cyc();
    check("hit_score", score, 1);
    check("hit_combo", combo, 1);
    check("hit_cleared", lane_view, 0);
    btn = '0;
    for (int i = 0; i < 10 && state != 2'd3; i++) cyc();
    check("hit_no_miss_score", score, 1);
    check("hit_done", state, 3);
    do_load({16'h0001, 16'h0001, 16'h0005, 16'h0007});
    period(4'hF);
    period(4'h1);
    check("mixed_pre_score", score, 5);
    period(4'h7);
    check("mixed_score", score, 6);
    check("mixed_combo", combo, 0);
    cyc();
    check("mixed_done", state, 3);
    do_load({4{16'hFFFF}});
    repeat (5) period(4'hF);
    check("sat_score", score, 15);
    check("sat_combo", combo, 15);
    do_load(64'h00F0);
    repeat (6) cyc();
    run = 0;
    cyc();
    check("pause_state", state, 2);
    frozen = lane_view;
    for (int i = 0; i < 20; i++) begin
      btn = (i < 16 && i[1]) ? 4'hF : 4'h0;
      cyc();
      check("pause_hold_state", state, 2);
      check("pause_no_tick", tick, 0);
      check("pause_frozen_view", lane_view, frozen);
      check("pause_score", score, 0);
    end
    run = 1;
    cyc();
    check("resume_state", state, 1);
    check("resume_tick0", tick, 0);
    cyc();
    check("resume_tick1", tick, 1);
    repeat (3) cyc();
    do_load(64'h000F);
    period(4'h1);
    check("pre_reset_score", score, 1);
    btn = 4'h1;
    cyc();
    do_reset();
    check("reset_state", state, 0);
    check("reset_score", score, 0);
    repeat (6) cyc();
    check("post_reset_idle", state, 0);
    check("post_reset_score", score, 0);
    btn = '0;
    for (int n = 0; n < 40; n++) begin
      run = 1;
      do_load({$urandom, $urandom} & {$urandom, $urandom});
      for (int c = 0; c < 60; c++) begin
        run = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 2) == 0) btn = 4'($urandom);
        cyc();
      end
      if (n % 10 == 9) do_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multi_lane_engine.md
MULTI_LANE_ENGINE -- requirements
Module: multi_lane_engine

Interface
REQ-001 Parameter NUM_LANES, default 4, number of independent note lanes.
REQ-002 Parameter LANE_LEN, default 64, note slots per lane.
REQ-003 Parameter VIEW_W, default 10, number of lowest lane bits exported per lane (1..LANE_LEN).
REQ-004 Parameter TICK_DIV, default 9000000, clk cycles per lane-shift tick (>=2).
REQ-005 Parameter SCORE_W, default 8, score width (unsigned).
REQ-006 Parameter COMBO_W, default 8, combo counter width (unsigned).
REQ-007 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-008 clk  in  1  system clock; all state on its rising edge.
REQ-009 resetn  in  1  asynchronous active-low reset.
REQ-010 run  in  1  level; 1 = play, 0 = pause.
REQ-011 load  in  1  single-cycle pulse; copies pattern_in into lanes.
REQ-012 pattern_in  in  NUM_LANES*LANE_LEN  lane i at bits [i*LANE_LEN +: LANE_LEN].
REQ-013 btn  in  NUM_LANES  raw asynchronous player inputs, one per lane.
REQ-014 lane_view  out  NUM_LANES*VIEW_W  bits [VIEW_W-1:0] of each lane, same packing.
REQ-015 score  out  SCORE_W  current score.
REQ-016 combo  out  COMBO_W  consecutive hits.
REQ-017 tick  out  1  one-cycle pulse on each lane shift.
REQ-018 state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-019 The FSM SHALL transition: IDLE->RUN when run=1 and a load has occurred since the last reset; RUN->PAUSE when run=0; PAUSE->RUN when run=1; RUN->DONE on the cycle after a tick leaves all lanes zero; any state->IDLE on load.
REQ-020 load SHALL, in the same edge, copy pattern_in to lanes, clear score, combo, and the divider; load has priority over every other event.
REQ-021 The divider SHALL count 0..TICK_DIV-1 only in RUN, hold in PAUSE, and assert tick for the cycle in which it equals TICK_DIV-1, then wrap to 0.
REQ-022 On tick, each lane SHALL shift right by one, with MSB filled 0; bit 0 is the hit slot.
REQ-023 btn SHALL pass a 2-flop synchroniser plus a 1-flop edge register; press = rising edge, one cycle wide.
REQ-024 The score/combo update from a btn rise SHALL occur on the 3rd clk edge after btn is sampled high.
REQ-025 Press in RUN with lane bit0=1 SHALL be a hit: bit0 cleared, score +1, combo +1.
REQ-026 Press in RUN with lane bit0=0 SHALL be a penalty: score -1, combo cleared.
REQ-027 A tick with bit0=1 not consumed in that cycle SHALL be a miss: score -1, combo cleared.
REQ-028 Press and tick in the same cycle on one lane: press SHALL be judged on pre-shift bit0; a consumed note SHALL NOT also count as a miss.
REQ-029 Events from all lanes in one cycle SHALL be summed as net delta = hits - (penalties + misses), applied once.
REQ-030 Score SHALL saturate at 0 and 2^SCORE_W-1; combo SHALL saturate at 2^COMBO_W-1.
REQ-031 Combo SHALL clear if any penalty or miss occurs in the cycle, else add the hit count.
REQ-032 Presses in IDLE, PAUSE, and DONE SHALL be ignored; synchronisers keep running.

Reset
REQ-033 resetn=0 SHALL immediately force state=IDLE, lanes=0, score=0, combo=0, tick=0, divider=0, synchronisers=0, and clear the loaded flag.
REQ-034 Reset mid-RUN SHALL discard all in-flight presses; after release, a load is required before RUN.

Verification (NUM_LANES=4, LANE_LEN=16, VIEW_W=4, TICK_DIV=4, SCORE_W=4, COMBO_W=4)
REQ-035 Load lane0=16'h0003, run=1 -> tick every 4 cycles; lane_view lane0 3->1->0; 2 misses; score stays 0 (floor); DONE after the 2nd tick.
REQ-036 Lane0=16'h0001; btn0 rises while bit0=1 -> score=1, combo=1, bit0 cleared; the next tick yields no miss.
REQ-037 btn on lanes 0,1,2 in the same cycle, bit0 = 1,1,0; score=5 -> score=6, combo=0.
REQ-038 Score=15; 4 simultaneous hits -> score=15, combo +4 saturating at 15.
REQ-039 run=0 for 20 cycles mid-game -> state=2, no tick, lanes and divider frozen, btn ignored; run=1 resumes the count from the frozen value.
REQ-040 Assert resetn=0 between the btn rise and the update edge -> score=0 and state=0; no update after release.
